// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    SEL    = 2'd0,
    D_BUSY = 2'd1,
    I_BUSY = 2'd2,
    ADV    = 2'd3
  } arb_state_e;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating count of consecutive memory wait cycles with a sticky timeout flag.
module mem_arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic timeout_flag
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(TIMEOUT)) ? v : v + 1'b1;
  endfunction

  assign cnt_inc = sat_inc(cnt);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt          <= '0;
      timeout_flag <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt_inc;
      if (cnt_inc == CNT_W'(TIMEOUT))
        timeout_flag <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises one data access then one fetch onto a single-port memory and
// pulses advance once both have completed.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] d_rdata,
  output logic              advance,
  output logic              err_conflict,
  output logic              err_timeout,
  output logic [31:0]       stall_cnt
);

  arb_state_e state, state_nxt;
  logic       is_read;
  logic       wd_clr;
  logic       wd_en;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= SEL;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEL:     state_nxt = (d_read || d_write) ? D_BUSY : I_BUSY;
      D_BUSY:  if (mem_ready) state_nxt = I_BUSY;
      I_BUSY:  if (mem_ready) state_nxt = ADV;
      ADV:     state_nxt = SEL;
      default: state_nxt = SEL;
    endcase
  end

  // Request/holding registers: the store wins over a simultaneous load.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      instr        <= '0;
      d_rdata      <= '0;
      advance      <= 1'b0;
      err_conflict <= 1'b0;
      is_read      <= 1'b0;
    end else begin
      advance <= 1'b0;
      case (state)
        SEL: begin
          mem_req <= 1'b1;
          if (d_write) begin
            mem_we    <= 1'b1;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            is_read   <= 1'b0;
          end else if (d_read) begin
            mem_we    <= 1'b0;
            mem_addr  <= d_addr;
            mem_wdata <= '0;
            is_read   <= 1'b1;
          end else begin
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            is_read   <= 1'b0;
          end
          if (d_read && d_write)
            err_conflict <= 1'b1;
        end
        D_BUSY: begin
          if (mem_ready) begin
            if (is_read)
              d_rdata <= mem_rdata;
            mem_addr  <= if_addr;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
          end
        end
        I_BUSY: begin
          if (mem_ready) begin
            instr   <= mem_rdata;
            mem_req <= 1'b0;
            advance <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)        stall_cnt <= '0;
    else if (!advance) stall_cnt <= stall_cnt + 32'd1;
  end

  assign wd_clr = (state == SEL) || (mem_req && mem_ready);
  assign wd_en  = mem_req;

  mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .clr          (wd_clr),
    .en           (wd_en),
    .timeout_flag (err_timeout)
  );

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port instruction/data memory between the IF stage (fetch) and the MEM stage (load/store driven by the EX/MEM register outputs).
- Serialises at most one data access and one fetch per instruction; the data access always goes first.
- Holds the whole pipeline until both accesses complete, then pulses `advance` so every pipeline register loads exactly once.
- Sits beside the pipeline registers; `advance` is their load enable.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data and instruction width.
- TIMEOUT, 16, cycles a memory request may wait for mem_ready before err_timeout sets (≥2).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- if_addr  in  ADDR_W  PC for the fetch; stable while advance=0.
- d_read  in  1  MEM-stage load request (MemtoReg of the EX/MEM register).
- d_write  in  1  MEM-stage store request (MemWrite).
- d_addr  in  ADDR_W  data address (ALUOut).
- d_wdata  in  DATA_W  store data (WriteData).
- mem_req  out  1  memory request.
- mem_we  out  1  write enable, valid with mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ready  in  1  memory completes the current request this cycle; mem_rdata valid.
- mem_rdata  in  DATA_W  memory read data.
- instr  out  DATA_W  fetched instruction, held until the next fetch completes.
- d_rdata  out  DATA_W  load data, held until the next load completes.
- advance  out  1  one-cycle pulse; pipeline registers load.
- err_conflict  out  1  sticky: d_read and d_write both seen at 1 in SEL.
- err_timeout  out  1  sticky: a request waited TIMEOUT cycles.
- stall_cnt  out  32  count of cycles with advance=0; wraps at 2^32.

Behaviour:
- Reset (RST_N=0, immediate, asynchronous):
  - state=SEL.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, instr, d_rdata, advance, err_*, stall_cnt.
  - Any in-flight request is abandoned; the memory must accept a dropped mem_req.
- FSM states: SEL, D_BUSY, I_BUSY, ADV.
- SEL:
  - If d_write: go to D_BUSY with mem_we=1, mem_addr=d_addr, mem_wdata=d_wdata.
  - Else if d_read: go to D_BUSY with mem_we=0, mem_addr=d_addr.
  - Else: go to I_BUSY with mem_we=0, mem_addr=if_addr.
  - mem_req is registered, so it is 1 from the first busy-state cycle.
- D_BUSY:
  - mem_req=1; mem_we/mem_addr/mem_wdata held stable.
  - On mem_ready: if a read, d_rdata<=mem_rdata. Then go to I_BUSY with mem_addr=if_addr, mem_we=0, mem_wdata=0.
- I_BUSY:
  - mem_req=1.
  - On mem_ready: instr<=mem_rdata, mem_req<=0, go to ADV.
- ADV: advance=1 for exactly this cycle, then go to SEL.
- mem_ready is ignored when mem_req=0.
- A zero-wait memory (mem_ready high in the first request cycle) is legal and completes in one cycle.
- Throughput with zero-wait memory:
  - 3 cycles per instruction with no data access.
  - 4 cycles per instruction with a data access.
  - Each memory wait cycle adds 1.
- Conflict: d_read and d_write both 1 in SEL → the store is performed, no load, err_conflict<=1.
- Watchdog:
  - Counts consecutive cycles with mem_req=1 and mem_ready=0; clears on mem_ready or in SEL.
  - When the count reaches TIMEOUT: err_timeout<=1, the request stays asserted, the count saturates.
- Sticky errors clear only on reset.
- stall_cnt increments on every cycle with advance=0, excluding reset cycles.
- d_read/d_write/d_addr/d_wdata/if_addr are sampled only in SEL and at the D_BUSY→I_BUSY transition; later changes are ignored until the next SEL.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (SEL, D_BUSY, I_BUSY, ADV; 2-bit encoding);
  - default ADDR_W/DATA_W/TIMEOUT constants.
- One sub-module, mem_arb_watchdog: saturating wait counter with clear/enable inputs and a timeout flag output.
- FSM, address/data muxing and holding registers stay in mem_port_arbiter.

Test Plan:
- No data access, mem_ready tied 1, if_addr=0x0000_0000 then 0x0000_0004 → advance every 3rd cycle, mem_we=0 always, mem_addr equals if_addr, stall_cnt=2 after the first advance.
- Load: d_read=1, d_addr=0x100, mem_ready after 2 wait cycles with 0xDEADBEEF; fetch returns 0x8C01_0004 zero-wait → d_rdata=0xDEADBEEF, instr=0x8C01_0004, advance 6 cycles after SEL.
- Store: d_write=1, d_addr=0x40, d_wdata=0x1234_5678, 3 wait cycles → mem_we=1, mem_addr=0x40, mem_wdata=0x1234_5678 held for all 4 request cycles; the next request has mem_we=0; d_rdata unchanged.
- d_read=d_write=1 in SEL → a single write to d_addr, no load, err_conflict=1 and remaining 1 across later instructions.
- TIMEOUT=8, mem_ready withheld → err_timeout rises on the 8th wait cycle, mem_req still 1; mem_ready later completes the transaction normally.
- RST_N driven low mid-D_BUSY (asynchronous, between edges) → mem_req and all outputs 0 immediately; after release, SEL then a fresh request for the current inputs.
